mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Load/store sequencing stage that sits directly upstream of the byte-addressed memory access controller.
- Accepts one memory request at a time from execute over a valid/ready handshake and range-checks it.
- Drives the access controller's addr/ren/wen/wdata/wmask for exactly one cycle, captures read data, and sign/zero-extends it per funct3.
- Returns the result to writeback over a second valid/ready handshake.

Parameters:
- BASE_ADDR, 64'h00000000_80000000, lowest legal byte address.
- MEM_BYTES, 64'h00000000_08000000, size of the legal window in bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  execute presents a request.
- req_ready  output  1  stage can accept; high only in IDLE.
- req_ren  input  1  request is a load.
- req_wen  input  1  request is a store.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data (low bytes), or pass-through value when neither ren nor wen.
- req_rd  input  5  destination register tag.
- mem_addr  output  64  byte address to access controller.
- mem_ren  output  1  read enable.
- mem_rdata  input  64  read data; combinational from mem_addr/mem_ren, byte 0 at addr.
- mem_wdata  output  64  store data, unshifted.
- mem_wmask  output  64  size mask in low bytes; byte-offset alignment is done downstream.
- mem_wen  output  1  write enable; write commits at the clk edge that ends ACCESS.
- resp_valid  output  1  result available.
- resp_ready  input  1  writeback accepts.
- resp_data  output  64  extended load data, pass-through value, or 0.
- resp_rd  output  5  registered req_rd.
- resp_fault  output  1  access fault (range, illegal funct3, ren&wen both set).

Behaviour:
- States: IDLE, ACCESS, RESP. Reset (async, rst_n=0): state=IDLE, all outputs and internal registers 0. req_ready=0 while rst_n=0.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, register addr/funct3/wdata/rd/ren/wen and compute fault:
    - ren&wen both set.
    - Load funct3=111.
    - Store funct3[2]=1.
    - addr<BASE_ADDR.
    - addr+size-1 > BASE_ADDR+MEM_BYTES-1, computed in 65 bits so carry-out counts as fault.
  - Access size: funct3[1:0] → 1/2/4/8 bytes.
  - Next state: ACCESS if (ren|wen) and no fault; otherwise RESP.
- ACCESS (exactly 1 cycle):
  - mem_addr=registered addr.
  - mem_ren=ren, mem_wen=wen.
  - mem_wdata=registered wdata.
  - mem_wmask=00..FF / 00..FFFF / 0000_0000_FFFF_FFFF / all-ones for size 1/2/4/8.
  - Load data is extended and captured at the closing edge:
    - LB sext[7:0], LH sext[15:0], LW sext[31:0], LD as-is.
    - LBU/LHU/LWU zero-extend.
  - For a store, resp_data=0.
  - Next state: RESP.
- Outside ACCESS, all mem_* outputs are 0. No memory strobe is ever asserted for a faulting or pass-through request.
- RESP:
  - resp_valid=1; resp_data/resp_rd/resp_fault are stable until accepted.
  - Fault gives resp_data=0. Pass-through (neither ren nor wen) gives resp_data=registered wdata.
  - When resp_ready=1 at an edge, go to IDLE. No new request is accepted in the same cycle.
- Latency: request accept → resp_valid = 2 cycles (memory op) or 1 cycle (fault or pass-through). Max throughput is one request per 3 cycles.
- Back-pressure: RESP holds indefinitely with outputs unchanged while resp_ready=0.
- Reset mid-operation: async reset in ACCESS deasserts mem_wen immediately, so no write commits. Reset in RESP drops resp_valid immediately.
- req_* inputs are ignored outside IDLE.

Test Plan:
- LB at 0x8000_0010, mem_rdata=0x...0000_0080 → one ACCESS cycle with mem_ren=1, addr 0x8000_0010; resp_data=0xFFFF_FFFF_FFFF_FF80, resp_fault=0, resp_valid 2 cycles after accept.
- SH at 0x8000_0003, wdata=0x1234_5678_9ABC_DEF0 → exactly one cycle with mem_wen=1, mem_wmask=0x0000_0000_0000_FFFF, mem_wdata unchanged; resp_data=0.
- LWU at BASE_ADDR+MEM_BYTES-2 → resp_fault=1 after 1 cycle; mem_ren/mem_wen never asserted.
- Pass-through with wdata=0xDEAD, resp_ready=0 for 5 cycles → resp_valid held and resp_data=0xDEAD stable; req_ready=0 throughout; IDLE on the first resp_ready=1 edge.
- SD issued, rst_n pulled low mid-ACCESS → mem_wen drops asynchronously; no memory write; all outputs 0; req_ready=1 after release.
- Back-to-back LD/LHU/illegal load funct3=111 → correct extension for each, fault on the third; the interval between consecutive req_ready rises matches the stated latencies.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Load/store sequencing stage between execute and the byte-addressed memory access controller.
// Range-checks one request at a time, strobes memory for one cycle, extends load data, returns a result.
module mem_stage_ctrl #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_BYTES = 64'h0000_0000_0800_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [2:0]  i_req_funct3,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic [63:0] o_mem_addr,
  output logic        o_mem_ren,
  input  logic [63:0] i_mem_rdata,
  output logic [63:0] o_mem_wdata,
  output logic [63:0] o_mem_wmask,
  output logic        o_mem_wen,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [63:0] o_resp_data,
  output logic [4:0]  o_resp_rd,
  output logic        o_resp_fault
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Last legal byte, widened so an access wrapping past 2^64 still compares as out of range.
  localparam logic [64:0] LAST_ADDR = {1'b0, BASE_ADDR} + {1'b0, MEM_BYTES} - 65'd1;

  state_t      r_state;
  state_t      w_nextState;
  logic [63:0] r_addr;
  logic [2:0]  r_funct3;
  logic [63:0] r_wdata;
  logic [4:0]  r_rd;
  logic        r_ren;
  logic        r_wen;
  logic        r_fault;
  logic [63:0] r_data;

  logic [3:0]  w_size;
  logic [64:0] w_endAddr;
  logic        w_fault;
  logic        w_accept;
  logic [63:0] w_loadExt;

  assign w_accept = (r_state == IDLE) && i_req_valid;

  always_comb begin
    w_size = 4'd1;
    case (i_req_funct3[1:0])
      2'b00:   w_size = 4'd1;
      2'b01:   w_size = 4'd2;
      2'b10:   w_size = 4'd4;
      default: w_size = 4'd8;
    endcase
  end

  assign w_endAddr = {1'b0, i_req_addr} + {61'd0, w_size} - 65'd1;

  assign w_fault = (i_req_ren && i_req_wen)
                || (i_req_ren && (i_req_funct3 == 3'b111))
                || (i_req_wen && i_req_funct3[2])
                || (i_req_addr < BASE_ADDR)
                || (w_endAddr > LAST_ADDR);

  always_comb begin
    w_loadExt = 64'd0;
    case (r_funct3)
      3'b000:  w_loadExt = {{56{i_mem_rdata[7]}},  i_mem_rdata[7:0]};
      3'b001:  w_loadExt = {{48{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b010:  w_loadExt = {{32{i_mem_rdata[31]}}, i_mem_rdata[31:0]};
      3'b011:  w_loadExt = i_mem_rdata;
      3'b100:  w_loadExt = {56'd0, i_mem_rdata[7:0]};
      3'b101:  w_loadExt = {48'd0, i_mem_rdata[15:0]};
      3'b110:  w_loadExt = {32'd0, i_mem_rdata[31:0]};
      default: w_loadExt = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_nextState = ((i_req_ren || i_req_wen) && !w_fault) ? ACCESS : RESP;
        end
      end
      ACCESS:  w_nextState = RESP;
      RESP: begin
        if (i_resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Request fields only change on accept and load data only in ACCESS, so RESP outputs hold steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= 64'd0;
      r_funct3 <= 3'd0;
      r_wdata  <= 64'd0;
      r_rd     <= 5'd0;
      r_ren    <= 1'b0;
      r_wen    <= 1'b0;
      r_fault  <= 1'b0;
      r_data   <= 64'd0;
    end else if (w_accept) begin
      r_addr   <= i_req_addr;
      r_funct3 <= i_req_funct3;
      r_wdata  <= i_req_wdata;
      r_rd     <= i_req_rd;
      r_ren    <= i_req_ren;
      r_wen    <= i_req_wen;
      r_fault  <= w_fault;
      r_data   <= (w_fault || i_req_ren || i_req_wen) ? 64'd0 : i_req_wdata;
    end else if (r_state == ACCESS) begin
      r_data   <= r_ren ? w_loadExt : 64'd0;
    end
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_mem_addr   = 64'd0;
    o_mem_ren    = 1'b0;
    o_mem_wen    = 1'b0;
    o_mem_wdata  = 64'd0;
    o_mem_wmask  = 64'd0;
    o_resp_valid = 1'b0;
    o_resp_data  = 64'd0;
    o_resp_rd    = 5'd0;
    o_resp_fault = 1'b0;
    case (r_state)
      IDLE: o_req_ready = rst_n;
      ACCESS: begin
        o_mem_addr  = r_addr;
        o_mem_ren   = r_ren;
        o_mem_wen   = r_wen;
        o_mem_wdata = r_wdata;
        case (r_funct3[1:0])
          2'b00:   o_mem_wmask = 64'h0000_0000_0000_00FF;
          2'b01:   o_mem_wmask = 64'h0000_0000_0000_FFFF;
          2'b10:   o_mem_wmask = 64'h0000_0000_FFFF_FFFF;
          default: o_mem_wmask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
      end
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_data  = r_data;
        o_resp_rd    = r_rd;
        o_resp_fault = r_fault;
      end
      default: o_req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a table of single requests plus hand-written
// sequences for back-pressure and reset during ACCESS / RESP.
module tb_mem_stage_ctrl;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
    logic [63:0] rdata;
    logic        expFault;
    logic [63:0] expData;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic        reqRen;
  logic        reqWen;
  logic [2:0]  reqFunct3;
  logic [63:0] reqAddr;
  logic [63:0] reqWdata;
  logic [4:0]  reqRd;
  logic [63:0] memAddr;
  logic        memRen;
  logic [63:0] memRdata;
  logic [63:0] memWdata;
  logic [63:0] memWmask;
  logic        memWen;
  logic        respValid;
  logic        respReady;
  logic [63:0] respData;
  logic [4:0]  respRd;
  logic        respFault;

  int checkCount = 0;
  int passCount  = 0;
  int writeCount = 0;
  vec_t vecs[16];

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst_n        (rstN),
    .i_req_valid  (reqValid),
    .o_req_ready  (reqReady),
    .i_req_ren    (reqRen),
    .i_req_wen    (reqWen),
    .i_req_funct3 (reqFunct3),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .i_req_rd     (reqRd),
    .o_mem_addr   (memAddr),
    .o_mem_ren    (memRen),
    .i_mem_rdata  (memRdata),
    .o_mem_wdata  (memWdata),
    .o_mem_wmask  (memWmask),
    .o_mem_wen    (memWen),
    .o_resp_valid (respValid),
    .i_resp_ready (respReady),
    .o_resp_data  (respData),
    .o_resp_rd    (respRd),
    .o_resp_fault (respFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A write commits on any rising edge that sees the write strobe.
  always @(posedge clk) begin
    if (memWen) writeCount++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, actual, expected);
    end
  endtask

  task automatic waitReady();
    int budget = 0;
    while (!reqReady && budget < 10) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!reqReady) checkOutput("reqReadyTimeout", 64'(reqReady), 64'd1);
  endtask

  // Presents one request and returns just after the accepting edge.
  task automatic applyStimulus(input logic ren, input logic wen, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd);
    waitReady();
    reqValid  = 1'b1;
    reqRen    = ren;
    reqWen    = wen;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wdata;
    reqRd     = rd;
    @(posedge clk); #1;
    reqValid  = 1'b0;
    reqRen    = 1'b0;
    reqWen    = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    int lat = 1;
    int strobes = 0;
    int readyWhileBusy = 0;
    logic memOp;
    logic [63:0] expMask;
    int size;
    memOp = (v.ren || v.wen) && !v.expFault;
    size = 1 << v.funct3[1:0];
    expMask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    memRdata = v.rdata;
    applyStimulus(v.ren, v.wen, v.funct3, v.addr, v.wdata, v.rd);
    while (!respValid && lat < 5) begin
      if (reqReady) readyWhileBusy++;
      if (memRen || memWen) begin
        strobes++;
        checkOutput("memAddr", memAddr, v.addr);
        checkOutput("memRen", 64'(memRen), 64'(v.ren));
        checkOutput("memWen", 64'(memWen), 64'(v.wen));
        checkOutput("memWdata", memWdata, v.wdata);
        checkOutput("memWmask", memWmask, expMask);
      end
      @(posedge clk); #1;
      lat++;
    end
    if (memRen || memWen) strobes++;
    if (reqReady) readyWhileBusy++;
    checkOutput("latency", 64'(lat), memOp ? 64'd2 : 64'd1);
    checkOutput("strobeCycles", 64'(strobes), memOp ? 64'd1 : 64'd0);
    checkOutput("reqReadyBusy", 64'(readyWhileBusy), 64'd0);
    checkOutput("respData", respData, v.expData);
    checkOutput("respFault", 64'(respFault), 64'(v.expFault));
    checkOutput("respRd", 64'(respRd), 64'(v.rd));
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    checkOutput("idleAfterResp", 64'(reqReady), 64'd1);
    checkOutput("respDropped", 64'(respValid), 64'd0);
  endtask

  initial begin
    int savedWrites;
    rstN      = 1'b0;
    reqValid  = 1'b0;
    reqRen    = 1'b0;
    reqWen    = 1'b0;
    reqFunct3 = 3'd0;
    reqAddr   = 64'd0;
    reqWdata  = 64'd0;
    reqRd     = 5'd0;
    memRdata  = 64'd0;
    respReady = 1'b0;

    //         ren wen f3      addr                     wdata                    rd     rdata                    flt expData
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0010, 64'd0,                   5'd1,  64'h0000_0000_0000_0080, 1'b0, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_0003, 64'h1234_5678_9ABC_DEF0, 5'd2,  64'd0,                   1'b0, 64'd0};
    vecs[2]  = '{1'b1, 1'b0, 3'b110, 64'h0000_0000_87FF_FFFE, 64'd0,                   5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0};
    vecs[3]  = '{1'b0, 1'b0, 3'b000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_DEAD, 5'd4,  64'd0,                   1'b0, 64'h0000_0000_0000_DEAD};
    vecs[4]  = '{1'b1, 1'b0, 3'b011, 64'h0000_0000_87FF_FFF8, 64'd0,                   5'd5,  64'hFEDC_BA98_7654_3210, 1'b0, 64'hFEDC_BA98_7654_3210};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 64'h0000_0000_8000_0100, 64'd0,                   5'd6,  64'hAAAA_BBBB_CCCC_8001, 1'b0, 64'h0000_0000_0000_8001};
    vecs[6]  = '{1'b1, 1'b0, 3'b111, 64'h0000_0000_8000_0100, 64'd0,                   5'd7,  64'h1111_2222_3333_4444, 1'b1, 64'd0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0040, 64'd0,                   5'd8,  64'h1111_1111_8000_0001, 1'b0, 64'hFFFF_FFFF_8000_0001};
    vecs[8]  = '{1'b1, 1'b0, 3'b100, 64'h0000_0000_8000_0041, 64'd0,                   5'd9,  64'h0000_0000_0000_00FF, 1'b0, 64'h0000_0000_0000_00FF};
    vecs[9]  = '{1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0042, 64'd0,                   5'd10, 64'hFFFF_FFFF_FFFF_7FFF, 1'b0, 64'h0000_0000_0000_7FFF};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 64'h0000_0000_7FFF_FFFF, 64'd0,                   5'd11, 64'h0000_0000_0000_0012, 1'b1, 64'd0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_00AA, 5'd12, 64'd0,                   1'b1, 64'd0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_00BB, 5'd13, 64'd0,                   1'b1, 64'd0};
    vecs[13] = '{1'b0, 1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_00CC, 5'd14, 64'd0,                   1'b1, 64'd0};
    vecs[14] = '{1'b0, 1'b1, 3'b011, 64'h0000_0000_8000_0008, 64'h0123_4567_89AB_CDEF, 5'd15, 64'd0,                   1'b0, 64'd0};
    vecs[15] = '{1'b1, 1'b0, 3'b010, 64'h0000_0000_87FF_FFFC, 64'd0,                   5'd31, 64'h0000_0000_7FFF_FFFF, 1'b0, 64'h0000_0000_7FFF_FFFF};

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rstReqReady", 64'(reqReady), 64'd0);
    checkOutput("rstRespValid", 64'(respValid), 64'd0);
    checkOutput("rstMemStrobes", 64'({memRen, memWen}), 64'd0);
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("releaseReqReady", 64'(reqReady), 64'd1);

    for (int i = 0; i < 16; i++) begin
      runVector(vecs[i]);
    end

    // Pass-through held under back-pressure; new requests are ignored meanwhile.
    applyStimulus(1'b0, 1'b0, 3'b000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_DEAD, 5'd20);
    checkOutput("bpRespValid", 64'(respValid), 64'd1);
    reqValid  = 1'b1;
    reqRen    = 1'b1;
    reqFunct3 = 3'b011;
    reqWdata  = 64'h0000_0000_0000_BEEF;
    reqRd     = 5'd9;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("bpHoldValid", 64'(respValid), 64'd1);
      checkOutput("bpHoldData", respData, 64'h0000_0000_0000_DEAD);
      checkOutput("bpHoldRd", 64'(respRd), 64'd20);
      checkOutput("bpReqReady", 64'(reqReady), 64'd0);
      checkOutput("bpNoStrobe", 64'({memRen, memWen}), 64'd0);
    end
    reqValid  = 1'b0;
    reqRen    = 1'b0;
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
    checkOutput("bpReleaseReady", 64'(reqReady), 64'd1);
    checkOutput("bpReleaseValid", 64'(respValid), 64'd0);

    // Reset during the write cycle of an SD must stop the write.
    savedWrites = writeCount;
    applyStimulus(1'b0, 1'b1, 3'b011, 64'h0000_0000_8000_0020, 64'h5555_AAAA_5555_AAAA, 5'd21);
    checkOutput("sdInAccess", 64'(memWen), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstMemWen", 64'(memWen), 64'd0);
    checkOutput("midRstMemAddr", memAddr, 64'd0);
    checkOutput("midRstMemWdata", memWdata, 64'd0);
    checkOutput("midRstRespValid", 64'(respValid), 64'd0);
    checkOutput("midRstReqReady", 64'(reqReady), 64'd0);
    @(posedge clk); #3;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("midRstNoWrite", 64'(writeCount), 64'(savedWrites));
    checkOutput("midRstReadyAfter", 64'(reqReady), 64'd1);
    checkOutput("midRstRespAfter", 64'(respValid), 64'd0);

    // Reset while in RESP drops the response immediately.
    applyStimulus(1'b0, 1'b0, 3'b000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0777, 5'd22);
    checkOutput("respRstBefore", 64'(respValid), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("respRstValid", 64'(respValid), 64'd0);
    checkOutput("respRstData", respData, 64'd0);
    @(posedge clk); #3;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("respRstReady", 64'(reqReady), 64'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
